// File: rtl/switch_input_conditioner_if.sv
// Snapshot event channel of the switch input conditioner.
// Producer posts stable-bus snapshots; consumer acknowledges with evt_ready.
interface switch_input_conditioner_if #(
  parameter int WIDTH = 14
);
  logic             evt_valid;
  logic             evt_ready;
  logic [WIDTH-1:0] evt_data;
  logic             evt_ovf;

  modport master (
    output evt_valid,
    output evt_data,
    output evt_ovf,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_data,
    input  evt_ovf,
    output evt_ready
  );
endinterface

// File: rtl/switch_input_conditioner.sv
// Switch bus synchronizer + per-channel debounce with edge pulses
// and a change-snapshot event channel with sticky overflow.
module switch_input_conditioner #(
  parameter int WIDTH           = 14,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           raw_in,
  output logic [WIDTH-1:0]           stable_o,
  output logic [WIDTH-1:0]           rise_o,
  output logic [WIDTH-1:0]           fall_o,
  switch_input_conditioner_if.master evt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] synced;

  logic [CW-1:0] cnt_q [WIDTH];
  logic [CW-1:0] cnt_d [WIDTH];

  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] flip;

  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             chg;
  logic             accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= raw_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // A mismatch must persist DEBOUNCE_CYCLES edges in a row; any match restarts it.
  always_comb begin
    flip = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (synced[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          flip[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    stable_d = stable_q ^ flip;
    rise_d   = flip & ~stable_q;
    fall_d   = flip & stable_q;
  end

  assign chg    = |flip;
  assign accept = valid_q & evt.evt_ready;

  // A fresh change always wins over an accept: the new snapshot replaces it.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    if (chg) begin
      valid_d = 1'b1;
      data_d  = stable_d;
      ovf_d   = valid_q & ~evt.evt_ready;
    end else if (accept) begin
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
    end
  end

  assign stable_o      = stable_q;
  assign rise_o        = rise_q;
  assign fall_o        = fall_q;
  assign evt.evt_valid = valid_q;
  assign evt.evt_data  = data_q;
  assign evt.evt_ovf   = ovf_q;

endmodule

// File: tb/tb_switch_input_conditioner.sv
// Bench for switch_input_conditioner: directed table, corner sequences
// and randomized traffic against a window-based reference model.
module tb_switch_input_conditioner;

  localparam int W  = 14;
  localparam int SS = 2;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] raw = '0;
  logic [W-1:0] stable_o, rise_o, fall_o;

  int total = 0;
  int bad   = 0;

  switch_input_conditioner_if #(.WIDTH(W)) eif ();

  switch_input_conditioner #(
    .WIDTH(W),
    .SYNC_STAGES(SS),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .raw_in(raw),
    .stable_o(stable_o),
    .rise_o(rise_o),
    .fall_o(fall_o),
    .evt(eif.master)
  );

  always #5 clk = ~clk;

  // Reference model: a channel changes level when the synchronized
  // samples of the last DC edges all disagree with its current level.
  logic [W-1:0] hist [$];
  logic [W-1:0] m_stable, m_rise, m_fall, m_data;
  logic         m_valid, m_ovf;

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < SS + DC; k++) hist.push_back('0);
    m_stable = '0;
    m_rise   = '0;
    m_fall   = '0;
    m_data   = '0;
    m_valid  = 1'b0;
    m_ovf    = 1'b0;
  endtask

  task automatic model_step(input logic [W-1:0] r, input logic rd);
    logic [W-1:0] chgmask;
    hist.push_back(r);
    if (hist.size() > 16) void'(hist.pop_front());
    chgmask = '1;
    for (int k = SS; k < SS + DC; k++) begin
      chgmask &= hist[hist.size() - 1 - k] ^ m_stable;
    end
    m_rise   = chgmask & ~m_stable;
    m_fall   = chgmask & m_stable;
    m_stable = m_stable ^ chgmask;
    if (chgmask != '0) begin
      m_ovf   = m_valid && !rd;
      m_valid = 1'b1;
      m_data  = m_stable;
    end else if (m_valid && rd) begin
      m_valid = 1'b0;
      m_ovf   = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step(raw, eif.evt_ready);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Continuous scoreboard on the falling edge.
  always @(negedge clk) begin
    chk("m_stable", 32'(stable_o), 32'(m_stable));
    chk("m_rise", 32'(rise_o), 32'(m_rise));
    chk("m_fall", 32'(fall_o), 32'(m_fall));
    chk("m_valid", 32'(eif.evt_valid), 32'(m_valid));
    chk("m_data", 32'(eif.evt_data), 32'(m_data));
    chk("m_ovf", 32'(eif.evt_ovf), 32'(m_ovf));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_stable"}, 32'(stable_o), 32'h0);
    chk({nm, "_rise"}, 32'(rise_o), 32'h0);
    chk({nm, "_fall"}, 32'(fall_o), 32'h0);
    chk({nm, "_valid"}, 32'(eif.evt_valid), 32'h0);
    chk({nm, "_data"}, 32'(eif.evt_data), 32'h0);
    chk({nm, "_ovf"}, 32'(eif.evt_ovf), 32'h0);
  endtask

  task automatic do_reset(input logic [W-1:0] r);
    rst_n = 1'b0;
    raw = r;
    eif.evt_ready = 1'b0;
    tick(3);
    chk_zero("rst");
    rst_n = 1'b1;
  endtask

  task automatic accept_one();
    eif.evt_ready = 1'b1;
    tick(1);
    eif.evt_ready = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] raw;
    logic         rdy;
    logic [W-1:0] stb;
    logic [W-1:0] rise;
    logic         vld;
    logic [W-1:0] dat;
  } vec_t;

  vec_t tbl [9];

  initial begin
    for (int k = 0; k < 5; k++) tbl[k] = '{14'h1, 1'b0, 14'h0, 14'h0, 1'b0, 14'h0};
    tbl[5] = '{14'h1, 1'b0, 14'h1, 14'h1, 1'b1, 14'h1};
    tbl[6] = '{14'h1, 1'b0, 14'h1, 14'h0, 1'b1, 14'h1};
    tbl[7] = '{14'h1, 1'b1, 14'h1, 14'h0, 1'b0, 14'h1};
    tbl[8] = '{14'h1, 1'b0, 14'h1, 14'h0, 1'b0, 14'h1};

    eif.evt_ready = 1'b0;

    // Single channel rise from all-zero
    do_reset('0);
    for (int k = 0; k < 9; k++) begin
      raw = tbl[k].raw;
      eif.evt_ready = tbl[k].rdy;
      tick(1);
      chk($sformatf("t2_stb%0d", k), 32'(stable_o), 32'(tbl[k].stb));
      chk($sformatf("t2_rise%0d", k), 32'(rise_o), 32'(tbl[k].rise));
      chk($sformatf("t2_vld%0d", k), 32'(eif.evt_valid), 32'(tbl[k].vld));
      chk($sformatf("t2_dat%0d", k), 32'(eif.evt_data), 32'(tbl[k].dat));
    end
    eif.evt_ready = 1'b0;

    // Glitch shorter than the debounce window
    for (int k = 0; k < 13; k++) begin
      raw = (k < 3) ? 14'h0021 : 14'h0001;
      tick(1);
      chk("t3_stb", 32'(stable_o), 32'h1);
      chk("t3_rise", 32'(rise_o), 32'h0);
      chk("t3_vld", 32'(eif.evt_valid), 32'h0);
    end

    // Overflow on a slow consumer
    raw = '0;
    tick(8);
    chk("t4_pre_fall", 32'(stable_o), 32'h0);
    accept_one();
    raw = 14'h0002;
    tick(10);
    chk("t4_first_dat", 32'(eif.evt_data), 32'h2);
    chk("t4_first_ovf", 32'(eif.evt_ovf), 32'h0);
    raw = 14'h0006;
    tick(8);
    chk("t4_vld", 32'(eif.evt_valid), 32'h1);
    chk("t4_dat", 32'(eif.evt_data), 32'h6);
    chk("t4_ovf", 32'(eif.evt_ovf), 32'h1);
    accept_one();
    chk("t4_acc_vld", 32'(eif.evt_valid), 32'h0);
    chk("t4_acc_ovf", 32'(eif.evt_ovf), 32'h0);

    // Accept on the same edge as a new change
    raw = 14'h0004;
    tick(8);
    raw = 14'h0000;
    tick(8);
    chk("t5_pre_ovf", 32'(eif.evt_ovf), 32'h1);
    raw = 14'h0008;
    tick(5);
    chk("t5_pre_stb", 32'(stable_o), 32'h0);
    eif.evt_ready = 1'b1;
    tick(1);
    eif.evt_ready = 1'b0;
    chk("t5_vld", 32'(eif.evt_valid), 32'h1);
    chk("t5_dat", 32'(eif.evt_data), 32'h8);
    chk("t5_ovf", 32'(eif.evt_ovf), 32'h0);
    accept_one();

    // Async reset mid-debounce
    raw = 14'h0018;
    tick(5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("t6_async");
    raw = '0;
    tick(2);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk("t6_rise", 32'(rise_o), 32'h0);
      chk("t6_vld", 32'(eif.evt_valid), 32'h0);
    end

    // Level held across reset is re-accepted
    do_reset(14'h3FFF);
    tick(5);
    chk("t1_early", 32'(stable_o), 32'h0);
    tick(1);
    chk("t1_stb", 32'(stable_o), 32'h3FFF);
    chk("t1_rise", 32'(rise_o), 32'h3FFF);
    chk("t1_vld", 32'(eif.evt_valid), 32'h1);
    chk("t1_dat", 32'(eif.evt_data), 32'h3FFF);
    tick(1);
    chk("t1_rise_end", 32'(rise_o), 32'h0);

    // Randomized traffic
    do_reset('0);
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < W; b++) begin
        if ($urandom_range(0, 9) == 0) raw[b] = ~raw[b];
      end
      eif.evt_ready = ($urandom_range(0, 3) == 0);
      if (c == 700) begin
        #2;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
      end
      tick(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
